// File: rtl/data_pulse_if.sv
// Output bundle of the data_pulse generator: serial line plus frame markers.
interface data_pulse_if;
  logic pulse_out;
  logic frame_start;
  logic in_gap;

  modport master (output pulse_out, output frame_start, output in_gap);
  modport slave  (input  pulse_out, input  frame_start, input  in_gap);
endinterface

// File: rtl/data_pulse.sv
// Free-running pulse-train beacon: sends PATTERN LSB first as fixed-length
// slots ('1' = PULSE_WIDTH-cycle high pulse at slot start, '0' = low slot),
// followed by GAP_SLOTS low slots, repeating forever.
module data_pulse #(
  parameter int unsigned                  DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0]        PATTERN     = 8'hA5,
  parameter int unsigned                  SLOT_LEN    = 8,
  parameter int unsigned                  PULSE_WIDTH = 3,
  parameter int unsigned                  GAP_SLOTS   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  data_pulse_if.master  bus
);

  localparam int unsigned TOTAL_SLOTS = DATA_WIDTH + GAP_SLOTS;
  localparam int unsigned CYC_W  = (SLOT_LEN > 1)    ? $clog2(SLOT_LEN)    : 1;
  localparam int unsigned SLOT_W = (TOTAL_SLOTS > 1) ? $clog2(TOTAL_SLOTS) : 1;

  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(SLOT_LEN - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(TOTAL_SLOTS - 1);
  localparam logic [SLOT_W-1:0] DATA_LAST = SLOT_W'(DATA_WIDTH - 1);
  localparam logic [CYC_W:0]    PW_VAL    = (CYC_W + 1)'(PULSE_WIDTH);

  if (DATA_WIDTH < 1) begin : g_err_dw
    $error("data_pulse: DATA_WIDTH must be >= 1");
  end
  if (SLOT_LEN < 1) begin : g_err_sl
    $error("data_pulse: SLOT_LEN must be >= 1");
  end
  if (PULSE_WIDTH < 1 || PULSE_WIDTH > SLOT_LEN) begin : g_err_pw
    $error("data_pulse: PULSE_WIDTH must be in 1..SLOT_LEN");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_GAP
  } state_t;

  state_t              r_state;
  logic [CYC_W-1:0]    r_cyc_cnt;
  logic [SLOT_W-1:0]   r_slot_cnt;
  logic                r_pulse_out;
  logic                r_frame_start;
  logic                r_in_gap;

  state_t              w_state_nxt;
  logic [CYC_W-1:0]    w_cyc_nxt;
  logic [SLOT_W-1:0]   w_slot_nxt;
  logic [DATA_WIDTH-1:0] w_bit_sel;
  logic                w_pat_bit;

  // Next-state/counter values; outputs are decoded from these so the
  // registered outputs line up with the counters they describe.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc_cnt;
    w_slot_nxt  = r_slot_cnt;
    if (r_state == ST_IDLE) begin
      w_state_nxt = ST_DATA;
      w_cyc_nxt   = '0;
      w_slot_nxt  = '0;
    end else if (r_cyc_cnt == CYC_LAST) begin
      w_cyc_nxt = '0;
      if (r_slot_cnt == SLOT_LAST) begin
        w_slot_nxt  = '0;
        w_state_nxt = ST_DATA;
      end else begin
        w_slot_nxt = r_slot_cnt + 1'b1;
        if (r_slot_cnt == DATA_LAST) begin
          w_state_nxt = ST_GAP;
        end
      end
    end else begin
      w_cyc_nxt = r_cyc_cnt + 1'b1;
    end
  end

  // Pattern bit for the upcoming slot; gap slots fall outside the word and read 0.
  always_comb begin
    w_bit_sel = DATA_WIDTH'(1) << w_slot_nxt;
    w_pat_bit = |(PATTERN & w_bit_sel);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cyc_cnt     <= '0;
      r_slot_cnt    <= '0;
      r_pulse_out   <= 1'b0;
      r_frame_start <= 1'b0;
      r_in_gap      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cyc_cnt     <= w_cyc_nxt;
      r_slot_cnt    <= w_slot_nxt;
      r_pulse_out   <= (w_state_nxt == ST_DATA) && w_pat_bit &&
                       ({1'b0, w_cyc_nxt} < PW_VAL);
      r_frame_start <= (w_state_nxt == ST_DATA) && (w_slot_nxt == '0) &&
                       (w_cyc_nxt == '0);
      r_in_gap      <= (w_state_nxt == ST_GAP);
    end
  end

  assign bus.pulse_out   = r_pulse_out;
  assign bus.frame_start = r_frame_start;
  assign bus.in_gap      = r_in_gap;

endmodule

// File: tb/tb_data_pulse.sv
// Bench for data_pulse: default configuration, merged-pulse configuration
// and a one-slot one-cycle configuration, all sharing clock and reset.
module tb_data_pulse;

  logic clk;
  logic rst_n;

  int unsigned total;
  int unsigned bad;

  data_pulse_if if_def ();
  data_pulse_if if_mrg ();
  data_pulse_if if_one ();

  data_pulse u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_def)
  );

  data_pulse #(
    .DATA_WIDTH  (8),
    .PATTERN     (8'h03),
    .SLOT_LEN    (4),
    .PULSE_WIDTH (4),
    .GAP_SLOTS   (0)
  ) u_dut_mrg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_mrg)
  );

  data_pulse #(
    .DATA_WIDTH  (1),
    .PATTERN     (1'b1),
    .SLOT_LEN    (1),
    .PULSE_WIDTH (1),
    .GAP_SLOTS   (0)
  ) u_dut_one (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_one)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        p;
    logic        fs;
    logic        gap;
  } vec_t;

  localparam int unsigned NVEC = 20;
  localparam int unsigned NRUN = 85;

  vec_t tbl [NVEC];
  logic rec_p   [NRUN+1];
  logic rec_fs  [NRUN+1];
  logic rec_gap [NRUN+1];
  logic rec_mp  [NRUN+1];
  logic rec_mfs [NRUN+1];
  logic rec_op  [NRUN+1];
  logic rec_ofs [NRUN+1];

  task automatic chk(input string name, input int unsigned cyc,
                     input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_def_pulse"}, 0, if_def.pulse_out,   1'b0);
    chk({tag, "_def_fs"},    0, if_def.frame_start, 1'b0);
    chk({tag, "_def_gap"},   0, if_def.in_gap,      1'b0);
    chk({tag, "_mrg_pulse"}, 0, if_mrg.pulse_out,   1'b0);
    chk({tag, "_one_pulse"}, 0, if_one.pulse_out,   1'b0);
    chk({tag, "_one_fs"},    0, if_one.frame_start, 1'b0);
  endtask

  // Hold reset over two edges, check outputs, release at a falling edge so the
  // next rising edge is cycle 1.
  task automatic reset_release();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic record(input int unsigned ncyc);
    for (int unsigned n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      #1;
      rec_p[n]   = if_def.pulse_out;
      rec_fs[n]  = if_def.frame_start;
      rec_gap[n] = if_def.in_gap;
      rec_mp[n]  = if_mrg.pulse_out;
      rec_mfs[n] = if_mrg.frame_start;
      rec_op[n]  = if_one.pulse_out;
      rec_ofs[n] = if_one.frame_start;
    end
  endtask

  task automatic check_run();
    int highs;
    int gaps;
    int starts;
    for (int unsigned i = 0; i < NVEC; i++) begin
      chk("tbl_pulse", tbl[i].cyc, rec_p[tbl[i].cyc],   tbl[i].p);
      chk("tbl_fs",    tbl[i].cyc, rec_fs[tbl[i].cyc],  tbl[i].fs);
      chk("tbl_gap",   tbl[i].cyc, rec_gap[tbl[i].cyc], tbl[i].gap);
    end
    highs  = 0;
    gaps   = 0;
    starts = 0;
    for (int unsigned n = 1; n <= 80; n++) begin
      if (rec_p[n])   highs++;
      if (rec_gap[n]) gaps++;
    end
    for (int unsigned n = 1; n <= 81; n++) begin
      if (rec_fs[n]) starts++;
    end
    chk_int("frame_high_cycles",  highs,  12);
    chk_int("frame_gap_cycles",   gaps,   16);
    chk_int("frame_start_count",  starts, 2);
    for (int unsigned n = 1; n <= 40; n++) begin
      chk("mrg_pulse", n, rec_mp[n], (n <= 8) || (n >= 33));
      chk("mrg_fs",    n, rec_mfs[n], (n == 1) || (n == 33));
    end
    for (int unsigned n = 1; n <= 20; n++) begin
      chk("one_pulse", n, rec_op[n],  1'b1);
      chk("one_fs",    n, rec_ofs[n], 1'b1);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;

    // PATTERN 8'hA5 -> '1' in slots 0,2,5,7; slot k starts at cycle 8k+1.
    tbl = '{
      '{1,  1'b1, 1'b1, 1'b0},
      '{2,  1'b1, 1'b0, 1'b0},
      '{3,  1'b1, 1'b0, 1'b0},
      '{4,  1'b0, 1'b0, 1'b0},
      '{9,  1'b0, 1'b0, 1'b0},
      '{16, 1'b0, 1'b0, 1'b0},
      '{17, 1'b1, 1'b0, 1'b0},
      '{19, 1'b1, 1'b0, 1'b0},
      '{20, 1'b0, 1'b0, 1'b0},
      '{25, 1'b0, 1'b0, 1'b0},
      '{41, 1'b1, 1'b0, 1'b0},
      '{43, 1'b1, 1'b0, 1'b0},
      '{44, 1'b0, 1'b0, 1'b0},
      '{57, 1'b1, 1'b0, 1'b0},
      '{59, 1'b1, 1'b0, 1'b0},
      '{64, 1'b0, 1'b0, 1'b0},
      '{65, 1'b0, 1'b0, 1'b1},
      '{80, 1'b0, 1'b0, 1'b1},
      '{81, 1'b1, 1'b1, 1'b0},
      '{83, 1'b1, 1'b0, 1'b0}
    };

    reset_release();
    record(NRUN);
    check_run();

    // Mid-pulse asynchronous reset at cycle 42, then a clean restart.
    reset_release();
    record(42);
    chk("pre_reset_pulse", 42, if_def.pulse_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async");
    reset_release();
    record(NRUN);
    check_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
